// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: frame-level controller around a 24x18 signed MAC.
// Takes (a, b) operand pairs framed by s_last_i. It drives the MAC operands
// and the accumulator clear with the skew the MAC pipeline needs. The
// finished dot product is presented on a valid/ready result port.
//
// Ports:
//   clk_i, rst_i            rising-edge clock, synchronous active-high reset
//   s_valid_i / s_ready_o   operand-pair handshake
//   s_a_i, s_b_i, s_last_i  signed operands and end-of-frame marker
//   m_valid_o / m_ready_i   result handshake
//   m_data_o                43-bit signed dot product (wraps modulo 2^43)
//   m_len_o                 beats summed in the presented frame
//   m_trunc_o               frame was closed by the MAX_LEN limit
//
// mult_accumulate is the MAC datapath: product register followed by an
// accumulator. Clear replaces the accumulator with the incoming product.

`timescale 1ns/1ps

module mult_accumulate (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               clear_i,
   input  logic signed [23:0] a_i,
   input  logic signed [17:0] b_i,
   output logic signed [42:0] res_o
);

   logic signed [41:0] prod_d, prod_q;
   logic signed [42:0] acc_d, acc_q;

   always_comb begin
      prod_d = 42'(a_i) * 42'(b_i);
      if (clear_i) begin
         acc_d = 43'(prod_q);
      end else begin
         acc_d = acc_q + 43'(prod_q);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prod_q <= '0;
         acc_q  <= '0;
      end else begin
         prod_q <= prod_d;
         acc_q  <= acc_d;
      end
   end

   assign res_o = acc_q;

endmodule

// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for the first beat of a frame
// ACC   | frame open, accepting further beats
// DRAIN | end beat accepted, last product entering the accumulator
// OUT   | result presented, waiting for m_ready_i
module mac_dot_sequencer #(
   parameter  int MAX_LEN = 64,
   localparam int LW      = $clog2(MAX_LEN + 1)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               s_valid_i,
   output logic               s_ready_o,
   input  logic signed [23:0] s_a_i,
   input  logic signed [17:0] s_b_i,
   input  logic               s_last_i,
   output logic               m_valid_o,
   input  logic               m_ready_i,
   output logic signed [42:0] m_data_o,
   output logic [LW-1:0]      m_len_o,
   output logic               m_trunc_o
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACC,
      ST_DRAIN,
      ST_OUT
   } state_t;

   state_t            state_d, state_q;
   logic [LW-1:0]     count_d, count_q;
   logic [LW-1:0]     len_d, len_q;
   logic              trunc_d, trunc_q;
   logic              clr_d, clr_q;

   logic              accept;
   logic              first_beat;
   logic              at_max;
   logic              end_beat;
   logic [LW-1:0]     beat_num;
   logic signed [23:0] mac_a;
   logic signed [17:0] mac_b;

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      len_d      = len_q;
      trunc_d    = trunc_q;
      clr_d      = 1'b0;
      s_ready_o  = 1'b0;
      m_valid_o  = 1'b0;

      case (state_q)
         ST_IDLE, ST_ACC: s_ready_o = 1'b1;
         ST_OUT:          m_valid_o = 1'b1;
         default:         s_ready_o = 1'b0;
      endcase

      accept     = s_valid_i & s_ready_o;
      first_beat = (state_q == ST_IDLE);
      // Ordinal of the beat being offered, counting from 1.
      beat_num   = first_beat ? LW'(1) : count_q + LW'(1);
      at_max     = (beat_num == LW'(MAX_LEN));
      end_beat   = s_last_i | at_max;

      // Idle cycles push zero products so the accumulator holds its value.
      mac_a = accept ? s_a_i : '0;
      mac_b = accept ? s_b_i : '0;

      if (accept) begin
         count_d = beat_num;
         // First product reaches the accumulator one cycle after accept.
         clr_d   = first_beat;
         if (end_beat) begin
            len_d   = beat_num;
            trunc_d = at_max & ~s_last_i;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (accept) state_d = end_beat ? ST_DRAIN : ST_ACC;
         end
         ST_ACC: begin
            if (accept && end_beat) state_d = ST_DRAIN;
         end
         ST_DRAIN: state_d = ST_OUT;
         ST_OUT: begin
            if (m_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         len_q   <= '0;
         trunc_q <= 1'b0;
         clr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         len_q   <= len_d;
         trunc_q <= trunc_d;
         clr_q   <= clr_d;
      end
   end

   mult_accumulate u_mac (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (clr_q),
      .a_i     (mac_a),
      .b_i     (mac_b),
      .res_o   (m_data_o)
   );

   assign m_len_o   = len_q;
   assign m_trunc_o = trunc_q;

endmodule
